// File: rtl/twos_complement_pkg.sv
// Shared types and constants for the bit-serial two's-complement unit.
package twos_complement_pkg;

  // Controller states: waiting for an operand, walking the bits, holding the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation select, sampled together with the operand.
  localparam logic MODE_NEGATE = 1'b0;
  localparam logic MODE_ABS    = 1'b1;

endpackage : twos_complement_pkg

// File: rtl/twos_complement_bit_cell.sv
// One step of the LSB-first two's-complement rule: bits up to and including
// the first 1 are copied, every bit after it is inverted (when inversion is on).
module twos_complement_bit_cell (
  input  logic a,
  input  logic found_one,
  input  logic invert_en,
  output logic r,
  output logic found_one_next
);

  assign r              = (found_one && invert_en) ? ~a : a;
  assign found_one_next = found_one | a;

endmodule : twos_complement_bit_cell

// File: rtl/twos_complement_serial.sv
// Bit-serial negate / absolute-value unit. One operand per transaction,
// WIDTH processing cycles, result held until the consumer takes it.
module twos_complement_serial
  import twos_complement_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_one_q, found_one_d;
  logic               invert_en_q, invert_en_d;
  logic               in_ready_q, in_ready_d;

  logic               cell_r;
  logic               cell_found_one;
  logic               done;

  // Per-bit rule applied to the bit currently at the bottom of the shift register.
  twos_complement_bit_cell u_bit_cell (
    .a              (shift_q[0]),
    .found_one      (found_one_q),
    .invert_en      (invert_en_q),
    .r              (cell_r),
    .found_one_next (cell_found_one)
  );

  // Next-state, datapath and handshake decisions.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    found_one_d = found_one_q;
    invert_en_d = invert_en_q;

    case (state_q)
      IDLE: begin
        // in_ready_q is low for one cycle after reset, so no accept happens then.
        if (in_valid && in_ready_q) begin
          shift_d     = in_data;
          // Abs of a non-negative operand must pass through untouched.
          invert_en_d = (in_mode == MODE_NEGATE) || in_data[WIDTH-1];
          cnt_d       = '0;
          found_one_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        shift_d     = {cell_r, shift_q[WIDTH-1:1]};
        found_one_d = cell_found_one;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is registered: it follows the state we are about to enter.
    in_ready_d = (state_d == IDLE);
  end

  // State, datapath and flag registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      found_one_q <= 1'b0;
      invert_en_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      found_one_q <= found_one_d;
      invert_en_q <= invert_en_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Outputs are qualified by DONE so they read zero whenever no result is held.
  // A result of 100..0 only arises from a 100..0 operand whose sign was flipped
  // (a non-negative operand in abs mode can never be 100..0), so it flags overflow.
  assign done      = (state_q == DONE);
  assign in_ready  = in_ready_q;
  assign out_valid = done;
  assign busy      = (state_q != IDLE);
  assign out_data  = done ? shift_q : '0;
  assign out_ovf   = done && (shift_q == MIN_VAL);
  assign out_zero  = done && (shift_q == '0);

endmodule : twos_complement_serial

// File: tb/tb_twos_complement_serial.sv
// Self-checking bench: 8-bit unit checked every cycle against a behavioural
// model, plus directed cases with literal expectations on 8- and 16-bit units.
module tb_twos_complement_serial;
  import twos_complement_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, in_mode8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] in_data8  = '0;
  logic       in_ready8, out_valid8, out_ovf8, out_zero8, busy8;
  logic [7:0] out_data8;

  logic        in_valid16 = 1'b0, in_mode16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] in_data16  = '0;
  logic        in_ready16, out_valid16, out_ovf16, out_zero16, busy16;
  logic [15:0] out_data16;

  int n_pass  = 0;
  int n_total = 0;
  int n_txn   = 0;

  twos_complement_serial #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_ovf(out_ovf8), .out_zero(out_zero8), .busy(busy8)
  );

  twos_complement_serial #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_mode(in_mode16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
    .out_ovf(out_ovf16), .out_zero(out_zero16), .busy(busy16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic on plain signed integers.
  function automatic int ref_int(input logic [7:0] x, input logic m);
    int sx;
    sx = $signed(x);
    return (m == MODE_ABS && sx >= 0) ? sx : -sx;
  endfunction
  function automatic logic [7:0] ref_data(input logic [7:0] x, input logic m);
    int r;
    r = ref_int(x, m);
    return r[7:0];
  endfunction
  function automatic logic ref_ovf(input logic [7:0] x, input logic m);
    return ref_int(x, m) > 127;
  endfunction
  function automatic logic ref_zero(input logic [7:0] x, input logic m);
    return ref_int(x, m) == 0;
  endfunction

  // Behavioural model of the 8-bit unit's handshake timing and result.
  logic       m_busy = 1'b0, m_rdy = 1'b0, m_mode = 1'b0;
  int         m_cnt  = 0;
  logic [7:0] m_opnd = '0, m_d = '0;
  logic       m_o = 1'b0, m_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_rdy  <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (m_rdy && in_valid8) begin
        m_busy <= 1'b1;
        m_rdy  <= 1'b0;
        m_cnt  <= 0;
        m_opnd <= in_data8;
        m_mode <= in_mode8;
        m_d    <= ref_data(in_data8, in_mode8);
        m_o    <= ref_ovf(in_data8, in_mode8);
        m_z    <= ref_zero(in_data8, in_mode8);
      end else begin
        m_rdy <= 1'b1;
      end
    end else if (m_cnt < 8) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready8) begin
      m_busy <= 1'b0;
      m_rdy  <= 1'b1;
      n_txn  <= n_txn + 1;
      $display("txn %0d w8: in=%02h mode=%s out=%02h ovf=%0d zero=%0d",
               n_txn, m_opnd, (m_mode == MODE_ABS) ? "abs" : "neg",
               out_data8, out_ovf8, out_zero8);
    end
  end

  // Every-cycle comparison of the 8-bit unit against the model.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready8), 32'(m_rdy));
    chk("out_valid", 32'(out_valid8), 32'(m_busy && m_cnt == 8));
    chk("busy", 32'(busy8), 32'(m_busy));
    if (m_busy && m_cnt == 8) begin
      chk("out_data", 32'(out_data8), 32'(m_d));
      chk("out_ovf", 32'(out_ovf8), 32'(m_o));
      chk("out_zero", 32'(out_zero8), 32'(m_z));
    end
    if (!rst_n) chk("reset out_data", 32'(out_data8), 32'd0);
  end

  // One 8-bit transaction with literal expectations; hold = cycles of backpressure.
  task automatic txn8(input logic [7:0] d, input logic m, input int hold,
                      input logic [7:0] ed, input logic eo, input logic ez, input string nm);
    int k;
    int lat;
    logic [7:0] held;
    k = 0;
    lat = 0;
    in_data8 = d; in_mode8 = m; in_valid8 = 1'b1; out_ready8 = (hold == 0);
    while (!in_ready8 && k < 40) begin @(posedge clk); #1; k++; end
    chk({nm, " accept"}, 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, 32'(lat), 32'd8);
    chk({nm, " data"}, 32'(out_data8), 32'(ed));
    chk({nm, " ovf"}, 32'(out_ovf8), 32'(eo));
    chk({nm, " zero"}, 32'(out_zero8), 32'(ez));
    held = out_data8;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " held data"}, 32'(out_data8), 32'(held));
      chk({nm, " held valid"}, 32'(out_valid8), 32'd1);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk({nm, " handshake"}, 32'(out_valid8), 32'd0);
  endtask

  task automatic txn16(input logic [15:0] d, input logic m,
                       input logic [15:0] ed, input logic eo, input logic ez, input string nm);
    int k;
    int lat;
    k = 0;
    lat = 0;
    in_data16 = d; in_mode16 = m; in_valid16 = 1'b1; out_ready16 = 1'b1;
    while (!in_ready16 && k < 40) begin @(posedge clk); #1; k++; end
    chk({nm, " accept"}, 32'(in_ready16), 32'd1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    while (!out_valid16 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, 32'(lat), 32'd16);
    chk({nm, " data"}, 32'(out_data16), 32'(ed));
    chk({nm, " ovf"}, 32'(out_ovf16), 32'(eo));
    chk({nm, " zero"}, 32'(out_zero16), 32'(ez));
    $display("txn w16: in=%04h mode=%0d out=%04h ovf=%0d zero=%0d",
             d, m, out_data16, out_ovf16, out_zero16);
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    chk({nm, " handshake"}, 32'(out_valid16), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       rm;
    int         rh;
    int         k;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("in_ready before first edge", 32'(in_ready8), 32'd0);
    @(posedge clk); #1;
    chk("in_ready after first edge", 32'(in_ready8), 32'd1);

    // Pin the reference model to hand-worked values.
    chk("model neg 05", 32'(ref_data(8'h05, MODE_NEGATE)), 32'h0000_00FB);
    chk("model abs FB", 32'(ref_data(8'hFB, MODE_ABS)), 32'h0000_0005);
    chk("model abs 80 ovf", 32'(ref_ovf(8'h80, MODE_ABS)), 32'd1);

    txn8(8'h05, MODE_NEGATE, 0, 8'hFB, 1'b0, 1'b0, "neg 05");
    txn8(8'h80, MODE_NEGATE, 0, 8'h80, 1'b1, 1'b0, "neg 80");
    txn8(8'h80, MODE_ABS,    1, 8'h80, 1'b1, 1'b0, "abs 80");
    txn8(8'h00, MODE_NEGATE, 0, 8'h00, 1'b0, 1'b1, "neg 00");
    txn8(8'hFB, MODE_ABS,    0, 8'h05, 1'b0, 1'b0, "abs FB");
    txn8(8'h05, MODE_ABS,    0, 8'h05, 1'b0, 1'b0, "abs 05");
    txn8(8'h7F, MODE_NEGATE, 2, 8'h81, 1'b0, 1'b0, "neg 7F");

    // Backpressure with in_valid held high the whole time.
    in_data8 = 8'h33; in_mode8 = MODE_NEGATE; in_valid8 = 1'b1; out_ready8 = 1'b0;
    k = 0;
    while (!in_ready8 && k < 40) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    in_data8 = 8'h44;
    k = 0;
    while (!out_valid8 && k < 40) begin @(posedge clk); #1; k++; end
    chk("bp first data", 32'(out_data8), 32'h0000_00CD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp stable data", 32'(out_data8), 32'h0000_00CD);
      chk("bp in_ready low", 32'(in_ready8), 32'd0);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("bp handshake done", 32'(out_valid8), 32'd0);
    chk("bp ready after handshake", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("bp next accepted", 32'(busy8), 32'd1);
    k = 0;
    while (!out_valid8 && k < 40) begin @(posedge clk); #1; k++; end
    chk("bp second data", 32'(out_data8), 32'h0000_00BC);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;

    // Randomized operands, modes and backpressure against the model.
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom);
      rm = 1'($urandom_range(1));
      rh = $urandom_range(3);
      txn8(rd, rm, rh, ref_data(rd, rm), ref_ovf(rd, rm), ref_zero(rd, rm), "rand");
    end

    // Reset pulse three cycles into SHIFT.
    in_data8 = 8'h5A; in_mode8 = MODE_NEGATE; in_valid8 = 1'b1;
    k = 0;
    while (!in_ready8 && k < 40) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy8), 32'd0);
    chk("rst out_valid", 32'(out_valid8), 32'd0);
    chk("rst in_ready", 32'(in_ready8), 32'd0);
    chk("rst out_data", 32'(out_data8), 32'd0);
    chk("rst out_ovf", 32'(out_ovf8), 32'd0);
    chk("rst out_zero", 32'(out_zero8), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("post-rst in_ready before edge", 32'(in_ready8), 32'd0);
    @(posedge clk); #1;
    chk("post-rst in_ready after edge", 32'(in_ready8), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    txn8(8'h01, MODE_NEGATE, 0, 8'hFF, 1'b0, 1'b0, "post-rst neg 01");

    // Wider instance.
    txn16(16'h0001, MODE_NEGATE, 16'hFFFF, 1'b0, 1'b0, "w16 neg 0001");
    txn16(16'h8000, MODE_NEGATE, 16'h8000, 1'b1, 1'b0, "w16 neg 8000");
    txn16(16'h8001, MODE_ABS,    16'h7FFF, 1'b0, 1'b0, "w16 abs 8001");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_twos_complement_serial

// File: doc/twos_complement_serial.md
# twos_complement_serial

Parametrised, bit-serial two's-complement unit: accepts one WIDTH-bit operand per transaction over a valid/ready handshake and returns either its negation or its absolute value. Processing is LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule, with overflow and zero flags. It is the sequential, width-generic successor to the team's 8-bit combinational negator, for area-constrained datapaths where WIDTH-cycle latency is acceptable.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  unit can accept an operand.
- in_data  input  WIDTH  operand, two's-complement signed.
- in_mode  input  1  0 = negate, 1 = absolute value; sampled with in_data.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_ovf  output  1  result not representable: operand was the most-negative value (100…0) and the operation changed its sign.
- out_zero  output  1  result is all-zero.
- busy  output  1  high in SHIFT or DONE.

## Operation
- Three-state FSM.
  - IDLE: in_ready = 1. On in_valid && in_ready, latch in_data into the shift register, latch in_mode, clear the bit counter and the found_one flag, and go to SHIFT.
  - SHIFT: runs for exactly WIDTH cycles. Each cycle processes the current LSB a:
    - r = (found_one && invert_en) ? ~a : a
    - found_one |= a
    - shift right, inserting r at the MSB.
    - invert_en = 1 for negate. For absolute value, invert_en = operand MSB, so a non-negative operand passes through unchanged.
    - When the counter reaches WIDTH-1, go to DONE.
  - DONE: out_valid = 1. out_data, out_ovf and out_zero are held stable until out_valid && out_ready; on that handshake, return to IDLE.
- Inputs are ignored while in_ready = 0.
- out_ovf = 1 when the operand equals 100…0 and invert_en = 1. In that case out_data = 100…0.
- out_zero = 1 only for a zero operand (result 0; the result of 100…0 is not zero).
- Arithmetic is modulo 2^WIDTH. No sign extension and no saturation.
- Latency is the same for every mode and operand value.

## Timing
- Reset (asynchronous on rst_n low):
  - state = IDLE
  - in_ready = 0, out_valid = 0, out_data = 0, out_ovf = 0, out_zero = 0, busy = 0
  - counter = 0, found_one = 0
- in_ready is registered. It rises on the first rising edge after rst_n is released, so the earliest accept is on the second edge after release.
- Latency: an operand accepted on edge E0 gives out_valid = 1 after edge E0 + WIDTH.
- Throughput: minimum accept-to-accept spacing is WIDTH + 2 edges (WIDTH shift edges, the output handshake edge, then the accept edge).
- in_ready is low from the accept edge until the edge that completes the output handshake.
- A new operand is never accepted in the same cycle as an output handshake.
- If out_ready is high when out_valid first rises, the handshake completes on the next edge.
- Reset asserted mid-SHIFT or in DONE:
  - the in-flight operation is discarded and no out_valid pulse follows;
  - all outputs return to their reset values immediately, without waiting for a clock edge.
- The counter is sized $clog2(WIDTH) bits and must not wrap during SHIFT.

## Structure
- Package twos_complement_pkg holds:
  - state_t enum {IDLE, SHIFT, DONE};
  - MODE_NEGATE = 1'b0, MODE_ABS = 1'b1.
- Sub-module twos_complement_bit_cell: the combinational per-bit rule (inputs a, found_one, invert_en; outputs r, found_one_next).
- The top level holds the FSM, shift register, counter and flag registers.

## Test plan
- WIDTH=8, in_data=0x05, mode negate:
  - out_data = 0xFB, ovf = 0, zero = 0;
  - out_valid rises exactly 8 edges after the accept edge.
- WIDTH=8, negate 0x80, then abs 0x80: both give out_data = 0x80 with ovf = 1. Negate 0x00 gives 0x00 with zero = 1, ovf = 0.
- WIDTH=8, abs 0xFB gives 0x05; abs 0x05 gives 0x05. Both have ovf = 0 and identical latency.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE with in_valid = 1 throughout.
  - outputs stay stable and in_ready stays 0;
  - after out_ready is raised, the handshake completes, and the next operand is accepted on the following edge.
- Reset pulse 3 cycles into SHIFT: all outputs go to zero asynchronously, no spurious out_valid, and in_ready returns one edge after release. A post-reset negate of 0x01 gives 0xFF.
- WIDTH=16: negate 0x0001 gives 0xFFFF. Negate 0x8000 gives 0x8000 with ovf = 1. Latency is 16 edges.
